dm_access_ctrl: RTL

Sequencer between the MEM stage and a word-wide, single-port, synchronous-read data memory that has no byte enables. It accepts one load or store request at a time (byte, halfword or word) and performs the access. Sub-word stores are done as a read-modify-write sequence. Sub-word loads return lane-extracted, sign- or zero-extended data. Misaligned requests complete with an error flag and never touch memory.

---
 rtl/dm_access_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: sequencer between the MEM stage and a word-wide,
// single-port, synchronous-read data memory without byte enables.
// It handles one load or store at a time (byte, halfword or word).
// Sub-word stores are done as a read-modify-write. Sub-word loads are
// lane-extracted and then sign- or zero-extended. Misaligned or illegal
// requests complete with err and never touch memory.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i              request valid (sampled only while ready_o=1)
//   we_i               1 = store, 0 = load
//   size_i             00 byte, 01 half, 10 word, 11 illegal
//   sign_ext_i         sub-word loads: 1 sign-extend, 0 zero-extend
//   addr_i, wdata_i    byte address, store data (low-aligned)
//   ready_o            idle, able to accept a request
//   done_o, err_o      one-cycle completion pulse, error qualifier
//   rdata_o            last successful load result
//   mem_addr_o         word index into the data memory
//   mem_re_o, mem_we_o memory read / write strobes
//   mem_wdata_o        memory write word
//   mem_rdata_i        memory read data (one cycle after mem_re_o)
module dm_access_ctrl #(
  parameter int unsigned AW = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [1:0]    size_i,
  input  logic          sign_ext_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  output logic          ready_o,
  output logic          done_o,
  output logic          err_o,
  output logic [31:0]   rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_re_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam int unsigned AL = AW + 2;  // latched byte-address width

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          we_q;
  logic [1:0]    size_q;
  logic          sext_q;
  logic [AL-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          cap_c;
  logic          misal_c;

  // Address bits above the memory index are intentionally dropped.
  logic unused_addr_c;
  assign unused_addr_c = ^addr_i[31:AL];

  // Lane extraction and extension of a loaded word.
  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [1:0]  sz,
                                           input logic [1:0]  a,
                                           input logic        sx);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: load_ext = {{24{sx & b[7]}}, b};
      SZ_HALF: load_ext = {{16{sx & h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  // Replace the target lane of the read word with the store data.
  function automatic logic [31:0] merge(input logic [31:0] w,
                                        input logic [31:0] d,
                                        input logic [1:0]  sz,
                                        input logic [1:0]  a);
    logic [31:0] m;
    m = w;
    if (sz == SZ_BYTE) begin
      case (a)
        2'd0:    m[7:0]   = d[7:0];
        2'd1:    m[15:8]  = d[7:0];
        2'd2:    m[23:16] = d[7:0];
        default: m[31:24] = d[7:0];
      endcase
    end else if (a[1]) begin
      m[31:16] = d[15:0];
    end else begin
      m[15:0] = d[15:0];
    end
    return m;
  endfunction

  // Misalignment / illegal-size check on the incoming request.
  always_comb begin
    misal_c = 1'b0;
    case (size_i)
      SZ_BYTE: misal_c = 1'b0;
      SZ_HALF: misal_c = addr_i[0];
      SZ_WORD: misal_c = (addr_i[1:0] != 2'b00);
      default: misal_c = 1'b1;
    endcase
  end

  // State register and result register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Request capture, only while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (cap_c) begin
      we_q    <= we_i;
      size_q  <= size_i;
      sext_q  <= sign_ext_i;
      addr_q  <= addr_i[AL-1:0];
      wdata_q <= wdata_i;
      err_q   <= misal_c;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    cap_c       = 1'b0;
    ready_o     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    mem_addr_o  = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = 32'h0;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (req_i) begin
          cap_c   = 1'b1;
          state_d = misal_c ? S_RESP : S_ACC;
        end
      end
      S_ACC: begin
        mem_addr_o = addr_q[AL-1:2];
        if (we_q && (size_q == SZ_WORD)) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = wdata_q;
          state_d     = S_RESP;
        end else begin
          mem_re_o = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_addr_o = addr_q[AL-1:2];
        if (we_q) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = merge(mem_rdata_i, wdata_q, size_q, addr_q[1:0]);
        end else begin
          rdata_d = load_ext(mem_rdata_i, size_q, addr_q[1:0], sext_q);
        end
        state_d = S_RESP;
      end
      default: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = S_IDLE;
      end
    endcase
  end

  assign rdata_o = rdata_q;

endmodule
